// File: rtl/tx_pkg.sv
// Shared definitions for the tx packet scheduler: word format and FSM encoding.
package tx_pkg;

  localparam int PKT_W = 139;

  // Word-type tag carried in bits [138:136] of every packet word.
  typedef enum logic [2:0] {
    HDR_MID  = 3'b100,
    HDR_HEAD = 3'b101,
    HDR_TAIL = 3'b110
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  function automatic logic is_tail(input logic [PKT_W-1:0] w);
    return w[PKT_W-1 -: 3] == HDR_TAIL;
  endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Rotating-priority picker: first requesting port after last_grant, wrapping.
module tx_rr_pick #(
  parameter int NPORT = 4,
  parameter int GW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    grant,
  output logic             grant_vld
);

  // Walk from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NPORT; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NPORT]) begin
        grant     = GW'((int'(last_grant) + k) % NPORT);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_sched_rr.sv
// Packet-granular round-robin scheduler feeding one tx packet/valid FIFO pair
// from NPORT show-ahead source FIFO pairs, with per-port fwd/drop counters.
module tx_sched_rr
  import tx_pkg::*;
#(
  parameter int         NPORT    = 4,
  parameter logic [7:0] USEDW_TH = 8'd161
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NPORT*PKT_W-1:0] src_pkt_q,
  input  logic [NPORT-1:0]       src_pkt_empty,
  output logic [NPORT-1:0]       src_pkt_rdreq,
  input  logic [NPORT-1:0]       src_valid_q,
  input  logic [NPORT-1:0]       src_valid_empty,
  output logic [NPORT-1:0]       src_valid_rdreq,
  output logic [PKT_W-1:0]       tx_pkt,
  output logic                   tx_pkt_wrreq,
  output logic                   tx_pkt_valid,
  output logic                   tx_pkt_valid_wrreq,
  input  logic [7:0]             tx_pkt_usedw,
  output logic [NPORT*16-1:0]    fwd_cnt,
  output logic [NPORT*16-1:0]    drop_cnt
);

  localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t                 r_state, w_next;
  logic [GW-1:0]          r_grant, r_last, w_pick;
  logic                   w_pick_vld, w_start, w_avail, w_tail, w_busy, w_fwd;
  logic [NPORT-1:0]       w_req;
  logic [PKT_W-1:0]       w_word;
  logic [NPORT-1:0][15:0] r_fwd, r_drop;

  assign w_req   = ~src_valid_empty;
  assign w_word  = src_pkt_q[int'(r_grant)*PKT_W +: PKT_W];
  assign w_avail = ~src_pkt_empty[r_grant];
  assign w_tail  = is_tail(w_word);
  assign w_busy  = (r_state == ST_XFER) || (r_state == ST_DROP);
  assign w_fwd   = (r_state == ST_XFER) && w_avail;
  // Fill level only gates the start of a packet; a started one always completes.
  assign w_start = (tx_pkt_usedw <= USEDW_TH) && w_pick_vld;

  tx_rr_pick #(.NPORT(NPORT), .GW(GW)) u_pick (
    .req        (w_req),
    .last_grant (r_last),
    .grant      (w_pick),
    .grant_vld  (w_pick_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= GW'(NPORT - 1);
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_start) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    src_pkt_rdreq   = '0;
    src_valid_rdreq = '0;
    case (r_state)
      ST_IDLE: if (w_start) w_next = src_valid_q[w_pick] ? ST_XFER : ST_DROP;
      ST_XFER, ST_DROP: begin
        if (w_avail) begin
          src_pkt_rdreq[r_grant] = 1'b1;
          if (w_tail) begin
            src_valid_rdreq[r_grant] = 1'b1;
            w_next                   = ST_WAIT;
          end
        end
      end
      // One dead cycle so tx_pkt_usedw reflects the packet just written.
      ST_WAIT: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_pkt             <= '0;
      tx_pkt_wrreq       <= 1'b0;
      tx_pkt_valid       <= 1'b0;
      tx_pkt_valid_wrreq <= 1'b0;
    end else begin
      tx_pkt_wrreq       <= w_fwd;
      tx_pkt_valid       <= w_fwd && w_tail;
      tx_pkt_valid_wrreq <= w_fwd && w_tail;
      if (w_fwd) tx_pkt <= w_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd  <= '0;
      r_drop <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (w_busy && w_avail && w_tail && r_grant == GW'(p)) begin
          if (r_state == ST_XFER) r_fwd[p]  <= r_fwd[p] + 16'd1;
          else                    r_drop[p] <= r_drop[p] + 16'd1;
        end
      end
    end
  end

  assign fwd_cnt  = r_fwd;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_tx_sched_rr.sv
// Randomized bench for tx_sched_rr: source FIFOs and a packet-level reference model.
module tb_tx_sched_rr;

  localparam int NP    = 4;
  localparam int W     = 139;
  localparam int DEPTH = 512;
  localparam int TH    = 161;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NP*W-1:0]   src_pkt_q = '0;
  logic [NP-1:0]     src_pkt_empty = '1;
  logic [NP-1:0]     src_pkt_rdreq;
  logic [NP-1:0]     src_valid_q = '0;
  logic [NP-1:0]     src_valid_empty = '1;
  logic [NP-1:0]     src_valid_rdreq;
  logic [W-1:0]      tx_pkt;
  logic              tx_pkt_wrreq, tx_pkt_valid, tx_pkt_valid_wrreq;
  logic [7:0]        tx_pkt_usedw = '0;
  logic [NP*16-1:0]  fwd_cnt, drop_cnt;

  always #5 clk = ~clk;

  tx_sched_rr #(.NPORT(NP), .USEDW_TH(8'd161)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .src_pkt_q          (src_pkt_q),
    .src_pkt_empty      (src_pkt_empty),
    .src_pkt_rdreq      (src_pkt_rdreq),
    .src_valid_q        (src_valid_q),
    .src_valid_empty    (src_valid_empty),
    .src_valid_rdreq    (src_valid_rdreq),
    .tx_pkt             (tx_pkt),
    .tx_pkt_wrreq       (tx_pkt_wrreq),
    .tx_pkt_valid       (tx_pkt_valid),
    .tx_pkt_valid_wrreq (tx_pkt_valid_wrreq),
    .tx_pkt_usedw       (tx_pkt_usedw),
    .fwd_cnt            (fwd_cnt),
    .drop_cnt           (drop_cnt)
  );

  // Source FIFOs as ring buffers with free-running pointers.
  logic [W-1:0] pm [NP][DEPTH];
  bit           vm [NP][DEPTH];
  int           pw [NP], pr [NP], vw [NP], vr [NP];
  bit           stall [NP];

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [NP-1:0] cap_pp = '0, cap_vp = '0;
  int wr_log[$], vw_log[$], head_log[$], headcyc_log[$];

  // Reference model: packet in progress, post-tail gap, rotation pointer.
  bit           m_busy, m_fwd_mode;
  int           m_gap, m_port, m_last;
  int           m_fwd [NP], m_drop [NP];
  bit           e_wr, e_vw;
  logic [W-1:0] e_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NP; i++) begin
      src_pkt_q[i*W +: W] = (pw[i] != pr[i]) ? pm[i][pr[i] % DEPTH] : '0;
      src_pkt_empty[i]    = (pw[i] == pr[i]) || stall[i];
      src_valid_q[i]      = (vw[i] != vr[i]) ? vm[i][vr[i] % DEPTH] : 1'b0;
      src_valid_empty[i]  = (vw[i] == vr[i]);
    end
  endtask

  function automatic logic [W-1:0] mkw(input logic [2:0] h);
    logic [135:0] pl;
    pl = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    return {h, pl};
  endfunction

  task automatic push_word(input int p, input logic [2:0] h);
    pm[p][pw[p] % DEPTH] = mkw(h);
    pw[p]++;
    drive_heads();
  endtask

  task automatic push_valid(input int p, input bit v);
    vm[p][vw[p] % DEPTH] = v;
    vw[p]++;
    drive_heads();
  endtask

  task automatic push_pkt(input int p, input int len, input bit v);
    for (int k = 0; k < len; k++)
      push_word(p, (k == len-1) ? 3'b110 : (k == 0) ? 3'b101 : 3'b100);
    push_valid(p, v);
  endtask

  // Advance one clock; apply the pops the DUT requested during the last cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (cap_pp[i] && pw[i] != pr[i]) pr[i]++;
      if (cap_vp[i] && vw[i] != vr[i]) vr[i]++;
    end
    cap_pp = '0;
    cap_vp = '0;
    drive_heads();
  endtask

  function automatic bit all_idle();
    bit r;
    r = !m_busy && (m_gap == 0);
    for (int i = 0; i < NP; i++) if (pw[i] != pr[i] || vw[i] != vr[i]) r = 0;
    return r;
  endfunction

  task automatic drain(input int maxc, input string nm);
    int n;
    n = 0;
    while (!all_idle() && n < maxc) begin tick(); n++; end
    chk(nm, W'(all_idle()), W'(1));
  endtask

  task automatic clear_logs();
    wr_log.delete(); vw_log.delete(); head_log.delete(); headcyc_log.delete();
  endtask

  // Upstream FIFOs share the reset, so they are flushed too.
  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < NP; i++) begin pr[i] = pw[i]; vr[i] = vw[i]; stall[i] = 0; end
    drive_heads();
    reset_n = 1'b1;
    clear_logs();
  endtask

  // Compare process: registered outputs vs last cycle's prediction, pops vs now.
  initial forever begin
    logic [NP-1:0] exp_pp, exp_vp;
    logic [W-1:0]  w, n_word;
    bit            n_wr, n_vw, tl, found;
    int            p, q;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_wrreq", W'(tx_pkt_wrreq), '0);
      chk("rst_vwrreq", W'(tx_pkt_valid_wrreq), '0);
      chk("rst_valid", W'(tx_pkt_valid), '0);
      chk("rst_tx_pkt", tx_pkt, '0);
      chk("rst_rdreq", W'({src_pkt_rdreq, src_valid_rdreq}), '0);
      chk("rst_cnt", W'({fwd_cnt, drop_cnt}), '0);
      m_busy = 0; m_gap = 0; m_last = NP - 1; m_port = 0; m_fwd_mode = 0;
      for (int i = 0; i < NP; i++) begin m_fwd[i] = 0; m_drop[i] = 0; end
      e_wr = 0; e_vw = 0; e_word = '0;
      cap_pp = '0; cap_vp = '0;
    end else begin
      chk("wrreq", W'(tx_pkt_wrreq), W'(e_wr));
      if (e_wr) chk("tx_pkt", tx_pkt, e_word);
      chk("valid_wrreq", W'(tx_pkt_valid_wrreq), W'(e_vw));
      if (e_vw) chk("tx_valid", W'(tx_pkt_valid), W'(1));
      for (int i = 0; i < NP; i++) begin
        chk("fwd_cnt", W'(fwd_cnt[i*16 +: 16]), W'(16'(m_fwd[i])));
        chk("drop_cnt", W'(drop_cnt[i*16 +: 16]), W'(16'(m_drop[i])));
      end
      exp_pp = '0; exp_vp = '0; n_wr = 0; n_vw = 0; n_word = '0;
      if (m_busy) begin
        p = m_port;
        if (pw[p] != pr[p] && !stall[p]) begin
          w = pm[p][pr[p] % DEPTH];
          tl = (w[138:136] == 3'b110);
          exp_pp[p] = 1'b1;
          if (m_fwd_mode) begin n_wr = 1; n_word = w; n_vw = tl; end
          if (tl) begin
            exp_vp[p] = 1'b1;
            m_busy = 0;
            m_gap = 1;
            if (m_fwd_mode) m_fwd[p] = (m_fwd[p] + 1) % 65536;
            else            m_drop[p] = (m_drop[p] + 1) % 65536;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (int'(tx_pkt_usedw) <= TH) begin
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          q = (m_last + k) % NP;
          if (!found && vw[q] != vr[q]) begin
            found = 1; m_port = q; m_last = q; m_busy = 1;
            m_fwd_mode = vm[q][vr[q] % DEPTH];
          end
        end
      end
      chk("pkt_rdreq", W'(src_pkt_rdreq), W'(exp_pp));
      chk("valid_rdreq", W'(src_valid_rdreq), W'(exp_vp));
      if (tx_pkt_wrreq) wr_log.push_back(cyc);
      if (tx_pkt_valid_wrreq) vw_log.push_back(cyc);
      for (int i = 0; i < NP; i++)
        if (src_pkt_rdreq[i] && pw[i] != pr[i] && pm[i][pr[i] % DEPTH][138:136] == 3'b101) begin
          head_log.push_back(i);
          headcyc_log.push_back(cyc);
        end
      cap_pp = src_pkt_rdreq;
      cap_vp = src_valid_rdreq;
      e_wr = n_wr; e_vw = n_vw; e_word = n_word;
    end
  end

  initial begin
    int c0, n, pushed, total;
    int ord [8];
    for (int i = 0; i < NP; i++) begin pw[i] = 0; pr[i] = 0; vw[i] = 0; vr[i] = 0; stall[i] = 0; end
    drive_heads();
    tick(); tick();
    reset_n = 1'b1;

    // 3-word forward on port 0
    do_reset();
    c0 = cyc;
    push_pkt(0, 3, 1);
    drain(50, "t1_drain");
    chk("t1_nwr", W'(wr_log.size()), W'(3));
    if (wr_log.size() == 3) begin
      chk("t1_wr0", W'(wr_log[0]), W'(c0 + 2));
      chk("t1_wr2", W'(wr_log[2]), W'(c0 + 4));
    end
    chk("t1_nvw", W'(vw_log.size()), W'(1));
    if (vw_log.size() == 1) chk("t1_vw", W'(vw_log[0]), W'(c0 + 4));
    chk("t1_fwd0", W'(fwd_cnt[15:0]), W'(1));

    // 2-word drop on port 1
    do_reset();
    push_pkt(1, 2, 0);
    drain(50, "t2_drain");
    chk("t2_nwr", W'(wr_log.size() + vw_log.size()), W'(0));
    chk("t2_drop1", W'(drop_cnt[31:16]), W'(1));
    chk("t2_fwd1", W'(fwd_cnt[31:16]), W'(0));
    chk("t2_popped", W'(pr[1] + vr[1]), W'(3));

    // rotation with two packets per port
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_pkt(p, 2 + $urandom_range(0, 3), 1);
    drain(400, "t3_drain");
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("t3_nheads", W'(head_log.size()), W'(8));
    if (head_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("t3_order", W'(head_log[i]), W'(ord[i]));

    // fill-level threshold
    do_reset();
    tx_pkt_usedw = 8'd162;
    push_pkt(2, 3, 1);
    repeat (6) tick();
    chk("t4_blocked", W'(head_log.size()), W'(0));
    tx_pkt_usedw = 8'd161;
    c0 = cyc;
    tick(); tick();
    chk("t4_nheads", W'(head_log.size()), W'(1));
    if (headcyc_log.size() == 1) chk("t4_grant_cyc", W'(headcyc_log[0]), W'(c0 + 1));
    tx_pkt_usedw = 8'd0;
    drain(50, "t4_drain");

    // source runs dry mid-packet for three cycles
    do_reset();
    push_word(0, 3'b101); push_word(0, 3'b100); push_valid(0, 1);
    c0 = cyc;
    repeat (6) tick();
    push_word(0, 3'b100); push_word(0, 3'b110);
    drain(50, "t5_drain");
    chk("t5_nwr", W'(wr_log.size()), W'(4));
    if (wr_log.size() == 4) begin
      chk("t5_wr1", W'(wr_log[1]), W'(c0 + 3));
      chk("t5_wr2", W'(wr_log[2]), W'(c0 + 7));
      chk("t5_wr3", W'(wr_log[3]), W'(c0 + 8));
    end
    chk("t5_nvw", W'(vw_log.size()), W'(1));

    // reset in the middle of a 4-word packet
    do_reset();
    push_pkt(0, 4, 1);
    tick(); tick();
    chk("t6_midpkt", W'(tx_pkt_wrreq), W'(1));
    reset_n = 1'b0;
    #2;
    chk("t6_async_wrreq", W'(tx_pkt_wrreq), W'(0));
    chk("t6_async_rdreq", W'(src_pkt_rdreq), W'(0));
    tick();
    do_reset();
    push_pkt(1, 2, 1);
    push_pkt(0, 2, 1);
    drain(100, "t6_drain");
    chk("t6_first", W'((head_log.size() > 0) ? head_log[0] : 9), W'(0));
    chk("t6_fwd0", W'(fwd_cnt[15:0]), W'(1));

    // randomized traffic
    do_reset();
    pushed = 0;
    for (int c = 0; c < 4000; c++) begin
      tx_pkt_usedw = ($urandom_range(0, 7) == 0) ? 8'(150 + $urandom_range(0, 29)) : 8'($urandom_range(0, 99));
      for (int i = 0; i < NP; i++) stall[i] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(0, NP - 1);
        if (pw[n] - pr[n] < DEPTH - 16 && vw[n] - vr[n] < DEPTH - 16) begin
          push_pkt(n, $urandom_range(1, 6), $urandom_range(0, 3) != 0);
          pushed++;
        end
      end
      drive_heads();
      tick();
    end
    for (int i = 0; i < NP; i++) stall[i] = 0;
    tx_pkt_usedw = 8'd0;
    drive_heads();
    drain(5000, "rand_drain");
    tick(); tick();
    total = 0;
    for (int i = 0; i < NP; i++) total += int'(fwd_cnt[i*16 +: 16]) + int'(drop_cnt[i*16 +: 16]);
    chk("rand_total", W'(total), W'(pushed));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_sched_rr.md
# tx_sched_rr

Packet-granular round-robin scheduler sharing the single 139-bit tx packet/valid FIFO pair among NPORT upstream sources (manage ack path, pass-through path, future sources). Each source presents a show-ahead 139-bit packet FIFO plus a 1-bit valid FIFO; the valid FIFO receives one entry per complete packet. The block picks one source per packet, forwards or drops it whole, and tracks per-port forwarded and dropped packet counts.

## Interface
- NPORT, 4: number of sources (2..8).
- USEDW_TH, 8'd161: a new packet starts only when tx_pkt_usedw <= USEDW_TH.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- src_pkt_q  in  NPORT*139  show-ahead packet FIFO heads; port i at [i*139 +: 139].
- src_pkt_empty  in  NPORT  packet FIFO empty per port.
- src_pkt_rdreq  out  NPORT  packet FIFO pop per port.
- src_valid_q  in  NPORT  show-ahead valid FIFO heads; 1 = forward, 0 = drop.
- src_valid_empty  in  NPORT  valid FIFO empty per port.
- src_valid_rdreq  out  NPORT  valid FIFO pop per port.
- tx_pkt  out  139  packet word to tx FIFO.
- tx_pkt_wrreq  out  1  tx packet write strobe.
- tx_pkt_valid  out  1  valid flag to tx valid FIFO.
- tx_pkt_valid_wrreq  out  1  tx valid write strobe.
- tx_pkt_usedw  in  8  tx packet FIFO fill level.
- fwd_cnt  out  NPORT*16  forwarded packets per port.
- drop_cnt  out  NPORT*16  dropped packets per port.

## Operation
- Word format: [138:136] 101 head, 100 middle, 110 tail; [135:0] passed untouched.
- States: IDLE, XFER, DROP, WAIT.
- IDLE: if tx_pkt_usedw <= USEDW_TH and any ~src_valid_empty[i], grant first such port starting at last_grant+1 mod NPORT; register grant, last_grant <= grant; go XFER if src_valid_q[grant]=1, else DROP. Otherwise stay.
- XFER: each cycle with ~src_pkt_empty[grant]: src_pkt_rdreq[grant]=1 (combinational), tx_pkt <= word, tx_pkt_wrreq <= 1. On word with [138:136]=110: src_valid_rdreq[grant]=1, tx_pkt_valid <= 1, tx_pkt_valid_wrreq <= 1, fwd_cnt[grant]++, go WAIT.
- DROP: same popping, no tx writes; on tail pop valid FIFO, drop_cnt[grant]++, go WAIT.
- WAIT: all strobes 0; one cycle, then IDLE (lets tx_pkt_usedw settle).
- Pop outputs are nonzero only for the granted port; at most one bit set.
- Counters 16-bit, wrap at 0xFFFF -> 0.

## Timing
- Reset: tx_pkt=0, tx_pkt_wrreq=0, tx_pkt_valid=0, tx_pkt_valid_wrreq=0, all rdreq=0, counters=0, last_grant=NPORT-1 (port 0 first), state IDLE.
- Grant at cycle T (IDLE); first pop T+1; first tx_pkt_wrreq T+2. L-word packet: wrreq T+2..T+L+1, valid_wrreq at T+L+1 coincident with tail write; next grant earliest T+L+2.
- Threshold checked only in IDLE; a started packet always completes regardless of usedw (USEDW_TH leaves headroom for a max packet).
- Packet FIFO empty mid-packet (upstream error): stall, no pop, strobes 0, resume when non-empty.
- Simultaneous requests: strict rotation; a port requesting continuously waits at most NPORT-1 packets.
- Valid FIFO write on same cycle as IDLE sample: visible next cycle only.
- Reset mid-packet: immediate return to reset values; partial packet left in tx FIFO is cleared by the shared reset.

## Structure
- Shared package tx_pkg: HDR_HEAD=3'b101, HDR_MID=3'b100, HDR_TAIL=3'b110, PKT_W=139, state encoding.
- Sub-module tx_rr_pick: combinational rotating priority picker (req[NPORT], last_grant -> grant, grant_vld).

## Test plan
- Port 0 only, valid=1, 3-word packet (101,100,110), usedw=0 -> three wrreq at T+2..T+4, valid_wrreq=1 with tail, fwd_cnt[0]=1.
- Port 1 valid=0, 2-word packet -> no tx writes, both words and valid popped, drop_cnt[1]=1, fwd_cnt[1]=0.
- Ports 0..3 each hold two packets -> output order 0,1,2,3,0,1,2,3.
- tx_pkt_usedw=162 with pending packet -> no grant; drop to 161 -> grant next cycle.
- Empty pkt FIFO for 3 cycles mid-packet -> 3-cycle gap in wrreq, payload intact, single valid write.
- Assert reset_n low during word 2 of 4 -> all outputs 0 next edge, port 0 serviced first after release.
